// File: rtl/fifo_arb_pkg.sv
// Shared types and constants for the FIFO write arbiter: FSM state encoding
// and the width of the optional per-requester beat counters.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } state_t;

    localparam int STAT_W = 16;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin pick: first set bit of req searching ptr, ptr+1, ...
// modulo NREQ. valid is low when no request is present.
module rr_pick #(
    parameter int NREQ = 4,
    parameter int PW   = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [PW-1:0]   ptr,
    output logic            valid,
    output logic [PW-1:0]   idx
);

    logic [PW-1:0] cand;

    // NOTE: every variable written here gets a default first so no latch is inferred.
    always_comb begin
        valid = 1'b0;
        idx   = '0;
        cand  = '0;
        // Walk from the farthest offset down so the closest hit to ptr is written last.
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = PW'((int'(ptr) + k) % NREQ);
            if (req[cand]) begin
                valid = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one sync_fifo write port from NREQ requesters.
// Define FIFO_WR_ARBITER_STATS_EN to add saturating per-requester accepted-beat counters.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int NREQ      = 4,
    parameter int BURST_LEN = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [NREQ-1:0]           req,
    input  logic [NREQ*WIDTH-1:0]     req_data,
    output logic [NREQ-1:0]           gnt,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [WIDTH-1:0]          fifo_wdata,
    output logic                      busy,
`ifdef FIFO_WR_ARBITER_STATS_EN
    input  logic [$clog2(NREQ)-1:0]   stat_sel,
    output logic [STAT_W-1:0]         stat_cnt,
`endif
    output logic [$clog2(NREQ)-1:0]   owner
);

    localparam int PW = $clog2(NREQ);
    localparam int CW = $clog2(BURST_LEN + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BURST_LEN - 1);

    state_t           state, state_nxt;
    logic [PW-1:0]    rr_ptr;
    logic [CW-1:0]    count;
    logic             pick_valid;
    logic [PW-1:0]    pick_idx;
    logic [WIDTH-1:0] slice [NREQ];
    logic             owner_req;
    logic             beat;
    logic             burst_done;

    rr_pick #(.NREQ(NREQ), .PW(PW)) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    always_comb begin
        for (int i = 0; i < NREQ; i++) slice[i] = req_data[i*WIDTH +: WIDTH];
    end

    assign owner_req  = req[owner];
    assign beat       = (state == BURST) && owner_req && !fifo_full;
    assign burst_done = (state == BURST) && (!owner_req || (beat && count == LAST_BEAT));

    // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:  if (pick_valid) state_nxt = BURST;
            BURST: if (burst_done) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt        = '0;
        fifo_wdata = '0;
        busy       = (state == BURST);
        if (state == BURST) begin
            gnt[owner] = beat;
            fifo_wdata = slice[owner];
        end
        fifo_wr_en = |gnt;
    end

    // Owner reads back as 0 whenever the arbiter is idle; the pointer advances only on burst exit.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            owner  <= '0;
            rr_ptr <= '0;
            count  <= '0;
        end else if (state == IDLE) begin
            if (pick_valid) begin
                owner <= pick_idx;
                count <= '0;
            end
        end else if (burst_done) begin
            owner  <= '0;
            count  <= '0;
            rr_ptr <= (owner == PW'(NREQ - 1)) ? '0 : owner + PW'(1);
        end else if (beat) begin
            count <= count + CW'(1);
        end
    end

`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [STAT_W-1:0] stat [NREQ];

    // NOTE: this counter array must read 0 after reset, so it is reset unlike a plain data memory.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREQ; i++) stat[i] <= '0;
        end else begin
            for (int i = 0; i < NREQ; i++)
                if (gnt[i] && stat[i] != '1) stat[i] <= stat[i] + STAT_W'(1);
        end
    end

    assign stat_cnt = stat[stat_sel];
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed self-checking bench for fifo_wr_arbiter (WIDTH=8, NREQ=4, BURST_LEN=4).
// Requester i presents data {i, beat index}; the bench advances the index after each expected grant.
module tb_fifo_wr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic        fifo_full;
    logic [3:0]  gnt;
    logic        fifo_wr_en;
    logic [7:0]  fifo_wdata;
    logic        busy;
    logic [1:0]  owner;
`ifdef FIFO_WR_ARBITER_STATS_EN
    logic [1:0]  stat_sel;
    logic [15:0] stat_cnt;
`endif

    int          total = 0;
    int          bad   = 0;
    logic [3:0]  seq [4];

    fifo_wr_arbiter #(.WIDTH(8), .NREQ(4), .BURST_LEN(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req        (req),
        .req_data   (req_data),
        .gnt        (gnt),
        .fifo_full  (fifo_full),
        .fifo_wr_en (fifo_wr_en),
        .fifo_wdata (fifo_wdata),
        .busy       (busy),
`ifdef FIFO_WR_ARBITER_STATS_EN
        .stat_sel   (stat_sel),
        .stat_cnt   (stat_cnt),
`endif
        .owner      (owner)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_data();
        for (int i = 0; i < 4; i++) req_data[i*8 +: 8] = {4'(i), seq[i]};
    endtask

    // One cycle: drive inputs after the falling edge, check combinational outputs
    // before the next rising edge, then note which requester's beat was consumed.
    task automatic cyc(input logic [3:0] r, input logic f, input logic [3:0] eg,
                       input logic eb, input logic [1:0] eo, input string tag);
        @(negedge clk);
        req       = r;
        fifo_full = f;
        drive_data();
        #1;
        check({tag, ".gnt"},   32'(gnt),        32'(eg));
        check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'(|eg));
        check({tag, ".busy"},  32'(busy),       32'(eb));
        check({tag, ".owner"}, 32'(owner),      32'(eo));
        if (eg != 4'b0000)
            check({tag, ".wdata"}, 32'(fifo_wdata), {24'b0, 2'b00, eo, seq[eo]});
        for (int i = 0; i < 4; i++) if (eg[i]) seq[i] = seq[i] + 4'd1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, ".gnt"},   32'(gnt),        32'h0);
        check({tag, ".wr_en"}, 32'(fifo_wr_en), 32'h0);
        check({tag, ".busy"},  32'(busy),       32'h0);
        check({tag, ".owner"}, 32'(owner),      32'h0);
        check({tag, ".wdata"}, 32'(fifo_wdata), 32'h0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 4; i++) seq[i] = 4'd0;
        rst       = 1'b0;
        req       = 4'b0000;
        fifo_full = 1'b0;
        drive_data();
`ifdef FIFO_WR_ARBITER_STATS_EN
        stat_sel  = 2'd0;
`endif
        repeat (2) @(negedge clk);
        #1;
        check_idle_outputs("por");
        @(negedge clk);
        rst = 1'b1;

        // Single requester 2 held for six beats: 4-beat burst, one idle cycle, then 2 more.
        cyc(4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, "single.arb");
        for (int k = 0; k < 4; k++) cyc(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, "single.b1");
        cyc(4'b0100, 1'b0, 4'b0000, 1'b0, 2'd0, "single.gap");
        for (int k = 0; k < 2; k++) cyc(4'b0100, 1'b0, 4'b0100, 1'b1, 2'd2, "single.b2");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd2, "single.drop");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "single.idle");

        // Reset mid-burst: pointer is 3, so requester 3 wins, then reset lands after one beat.
        cyc(4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, "rst.arb");
        cyc(4'b1111, 1'b0, 4'b1000, 1'b1, 2'd3, "rst.beat");
        @(negedge clk);
        rst = 1'b0;
        #1;
        check_idle_outputs("rst.mid");
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_idle_outputs("rst.rel");

        // Fairness: the edge after release picks requester 0; eight bursts rotate 0..3 twice.
        for (int b = 0; b < 8; b++) begin
            if (b > 0) cyc(4'b1111, 1'b0, 4'b0000, 1'b0, 2'd0, "fair.gap");
            for (int k = 0; k < 4; k++)
                cyc(4'b1111, 1'b0, 4'(1 << (b % 4)), 1'b1, 2'(b % 4), "fair.beat");
        end
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "fair.end");

`ifdef FIFO_WR_ARBITER_STATS_EN
        for (int s = 0; s < 4; s++) begin
            stat_sel = 2'(s);
            #1;
            check("stat.cnt", 32'(stat_cnt), 32'd8);
        end
`endif

        // Backpressure on requester 0: two beats, three full cycles, last two beats.
        cyc(4'b0001, 1'b0, 4'b0000, 1'b0, 2'd0, "bp.arb");
        for (int k = 0; k < 2; k++) cyc(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, "bp.pre");
        for (int k = 0; k < 3; k++) cyc(4'b0001, 1'b1, 4'b0000, 1'b1, 2'd0, "bp.full");
        for (int k = 0; k < 2; k++) cyc(4'b0001, 1'b0, 4'b0001, 1'b1, 2'd0, "bp.post");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "bp.end");

        // Early release: requester 1 leaves after two beats; search resumes from 2 and finds 3.
        cyc(4'b1010, 1'b0, 4'b0000, 1'b0, 2'd0, "early.arb");
        for (int k = 0; k < 2; k++) cyc(4'b1010, 1'b0, 4'b0010, 1'b1, 2'd1, "early.b");
        cyc(4'b1000, 1'b0, 4'b0000, 1'b1, 2'd1, "early.drop");
        cyc(4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, "early.rearb");
        cyc(4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, "early.own3");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b1, 2'd3, "early.exit");
        cyc(4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, "early.idle");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
